dec_codeword_assembler: RTL and testbench
=========================================

Name: dec_codeword_assembler

Overview:
- Upstream input stage of the decoder.
- Accepts a byte-wide stream with a valid/ready handshake and assembles 8-, 16- or 32-bit codewords according to the codeword width latched at the start of each codeword.
- Presents each complete codeword and its width to the combinational decoder through a registered valid/ready output slot.
- Keeps status counters for delivered codewords and dropped partial codewords.

Parameters:
- CNT_W, 16, width of the cw_count and drop_count status counters (wrap-around).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- cfg_width  input  2  codeword width select: 00=8 bit, 01=16 bit, 10/11=32 bit (11 aliases 32, matching the decoder's priority on bit 1).
- in_byte  input  8  stream data byte.
- in_valid  input  1  in_byte valid.
- in_last  input  1  frame-end marker, qualified by in_valid.
- in_ready  output  1  stage can accept in_byte this cycle.
- codeword  output  32  assembled codeword, zero-extended; feeds decoder codeword.
- codeword_width  output  2  width latched for this codeword; feeds decoder codeword_width.
- cw_valid  output  1  codeword/codeword_width valid.
- cw_ready  input  1  consumer accepts codeword this cycle.
- cw_count  output  CNT_W  codewords delivered (cw_valid && cw_ready), wraps.
- drop_count  output  CNT_W  partial codewords discarded on in_last, wraps.

Behaviour:
- Reset (rst_n=0 at a clk edge): in_ready=0 during reset, then 1 on the first cycle after reset release. cw_valid=0, codeword=0, codeword_width=0, cw_count=0, drop_count=0, byte counter=0, latched width=00, assembly register=0.
- Bytes per codeword: 1 for width 00, 2 for 01, 4 for 10/11.
- Byte accept: in_valid && in_ready.
- Width latch: on an accept with byte counter=0, cfg_width is latched. cfg_width changes mid-codeword are ignored until the next codeword.
- Byte order: byte k goes to bits [8k+7:8k], LSB-first. Bits above the codeword width are 0.
- States (implicit in byte counter + output slot):
  - IDLE: counter=0.
  - COLLECT: 0<counter<N.
  - Output slot: FULL when cw_valid=1, EMPTY when cw_valid=0.
- Completion: on an accept where counter=N-1, the assembled word (including the current byte) and the latched width load the output register on the same edge. cw_valid=1 from the next cycle (latency 1 cycle from the last byte). The counter returns to 0 and the assembly register clears.
- in_ready is 0 when counter=N-1, cw_valid=1 and cw_ready=0; otherwise 1. Simultaneous drain and load is allowed, giving full throughput.
- Output hold: while cw_valid && !cw_ready, codeword and codeword_width are stable.
- cw_valid clears after cw_ready unless a new word loads on the same edge.
- cw_count increments on each output handshake.
- in_last on an accepted byte that completes a codeword: normal completion, no drop.
- in_last on an accepted byte that does not complete a codeword: the partial word is discarded, the counter resets to 0 and drop_count increments. No output is produced.
- in_last on an accepted single byte with width 00: always a completion.
- Counters wrap from all-ones to 0 silently.
- Reset mid-operation: a partial word and a pending output are discarded, with no cw_valid after reset.

Decomposition:
- Shared package dec_pkg:
  - Typedef cw_width_t (2-bit) with enumerated values W8=2'b00, W16=2'b01, W32=2'b10.
  - Function bytes_per_cw(cw_width_t) returning 1/2/4, with 11 mapping to 4.
  - Constant CW_MAX_W=32.
- One natural sub-module: dec_cw_out_slot, a single-entry valid/ready register holding codeword and codeword_width, reusable downstream.

Test Plan:
- Width 00, bytes 0xA5, 0x3C back-to-back, cw_ready=1 → codewords 0x000000A5 then 0x0000003C, each one cycle after its byte; cw_count=2.
- Width 01, bytes 0x34, 0x12, cw_ready=1 → codeword=0x00001234, codeword_width=01.
- Width 10, bytes 0x78,0x56,0x34,0x12; cfg_width switched to 00 after the first byte → codeword=0x12345678, codeword_width=10.
- Width 11 → same assembly as width 10, codeword_width=11 passed through.
- Width 10, cw_ready=0 with one word already pending, send four more bytes → in_ready=0 while holding the fourth byte. Then raise cw_ready for one cycle → first word drains and the second loads on the same edge; no byte is lost and cw_count=1.
- Width 01, byte 0xEE with in_last=1 → no cw_valid, drop_count=1. The next bytes 0x01, 0x02 → codeword=0x00000201.
- Reset asserted with 2 of 4 bytes collected and cw_valid=1 → after release: cw_valid=0, both counters 0, in_ready=1. The next 4 bytes form a clean word.

Source files
------------

// File: rtl/dec_pkg.sv
// Shared decoder types: codeword width encoding and bytes-per-codeword helper.
// Width 2'b11 is not an enum member but aliases 32-bit, matching the decoder's bit-1 priority.
package dec_pkg;

    localparam int CW_MAX_W = 32;

    typedef enum logic [1:0] {
        W8  = 2'b00,
        W16 = 2'b01,
        W32 = 2'b10
    } cw_width_t;

    function automatic logic [2:0] bytes_per_cw(input cw_width_t w);
        case (w)
            W8:      return 3'd1;
            W16:     return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/dec_cw_out_slot.sv
// Single-entry valid/ready register for a codeword and its width; latency 1 cycle from load.
// Holds contents stable while cw_valid && !cw_ready; space allows drain and load on one edge.
module dec_cw_out_slot
    import dec_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [CW_MAX_W-1:0] load_cw,
    input  logic [1:0]          load_width,
    output logic [CW_MAX_W-1:0] codeword,
    output logic [1:0]          codeword_width,
    output logic                cw_valid,
    input  logic                cw_ready,
    output logic                space
);

    assign space = !cw_valid || cw_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            codeword       <= '0;
            codeword_width <= '0;
            cw_valid       <= 1'b0;
        end else if (load) begin
            codeword       <= load_cw;
            codeword_width <= load_width;
            cw_valid       <= 1'b1;
        end else if (cw_ready) begin
            cw_valid       <= 1'b0;
        end
    end

endmodule

// File: rtl/dec_codeword_assembler.sv
// Assembles LSB-first bytes into 8/16/32-bit codewords; output valid 1 cycle after the last byte.
// in_ready drops only when the final byte of a codeword would hit a full, stalled output slot.
module dec_codeword_assembler
    import dec_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          cfg_width,
    input  logic [7:0]          in_byte,
    input  logic                in_valid,
    input  logic                in_last,
    output logic                in_ready,
    output logic [CW_MAX_W-1:0] codeword,
    output logic [1:0]          codeword_width,
    output logic                cw_valid,
    input  logic                cw_ready,
    output logic [CNT_W-1:0]    cw_count,
    output logic [CNT_W-1:0]    drop_count
);

    logic [1:0]          cnt;
    logic [1:0]          lat_width;
    logic [CW_MAX_W-1:0] asm_q;
    logic [CW_MAX_W-1:0] asm_next;
    logic [1:0]          eff_width;
    logic [2:0]          n_bytes;
    logic                last_byte;
    logic                accept;
    logic                complete;
    logic                drop;
    logic                slot_space;

    // The first byte of a codeword uses cfg_width directly; later bytes use the latched copy.
    assign eff_width = (cnt == 2'd0) ? cfg_width : lat_width;
    assign n_bytes   = bytes_per_cw(cw_width_t'(eff_width));
    assign last_byte = ({1'b0, cnt} == (n_bytes - 3'd1));

    assign in_ready  = rst_n && !(last_byte && !slot_space);
    assign accept    = in_valid && in_ready;
    assign complete  = accept && last_byte;
    assign drop      = accept && in_last && !last_byte;
    assign asm_next  = asm_q | (CW_MAX_W'(in_byte) << {cnt, 3'b000});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            lat_width  <= '0;
            asm_q      <= '0;
            cw_count   <= '0;
            drop_count <= '0;
        end else begin
            if (accept && cnt == 2'd0) begin
                lat_width <= cfg_width;
            end
            if (complete || drop) begin
                cnt   <= '0;
                asm_q <= '0;
            end else if (accept) begin
                cnt   <= cnt + 2'd1;
                asm_q <= asm_next;
            end
            if (cw_valid && cw_ready) begin
                cw_count <= cw_count + CNT_W'(1);
            end
            if (drop) begin
                drop_count <= drop_count + CNT_W'(1);
            end
        end
    end

    dec_cw_out_slot u_out_slot (
        .clk            (clk),
        .rst_n          (rst_n),
        .load           (complete),
        .load_cw        (asm_next),
        .load_width     (eff_width),
        .codeword       (codeword),
        .codeword_width (codeword_width),
        .cw_valid       (cw_valid),
        .cw_ready       (cw_ready),
        .space          (slot_space)
    );

endmodule

// File: tb/tb_dec_codeword_assembler.sv
// Directed and randomized bench for dec_codeword_assembler against a byte-queue reference model.
module tb_dec_codeword_assembler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  cfg_width;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [31:0] codeword;
    logic [1:0]  codeword_width;
    logic        cw_valid;
    logic        cw_ready;
    logic [15:0] cw_count;
    logic [15:0] drop_count;

    always #5 clk = ~clk;

    dec_codeword_assembler #(.CNT_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_width      (cfg_width),
        .in_byte        (in_byte),
        .in_valid       (in_valid),
        .in_last        (in_last),
        .in_ready       (in_ready),
        .codeword       (codeword),
        .codeword_width (codeword_width),
        .cw_valid       (cw_valid),
        .cw_ready       (cw_ready),
        .cw_count       (cw_count),
        .drop_count     (drop_count)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: bytes of the codeword in progress plus the pending output word.
    bit          m_known = 0;
    logic [7:0]  m_bytes[$];
    logic [1:0]  m_lw;
    bit          m_pv;
    logic [31:0] m_pw;
    logic [1:0]  m_pwidth;
    logic [15:0] m_cwc;
    logic [15:0] m_drc;

    function automatic int nbytes(input logic [1:0] w);
        return (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        int n;
        n = nbytes((m_bytes.size() == 0) ? cfg_width : m_lw);
        return rst_n && !((m_bytes.size() == n - 1) && m_pv && !cw_ready);
    endfunction

    // One clock cycle: drive at negedge, compare DUT with model, then advance model past the posedge.
    task automatic cyc(input bit rst, input bit v, input logic [7:0] b, input bit last,
                       input logic [1:0] w, input bit rdy);
        bit          ready;
        bit          new_pv;
        logic [31:0] word;
        int          n;
        @(negedge clk);
        rst_n = rst; in_valid = v; in_byte = b; in_last = last; cfg_width = w; cw_ready = rdy;
        #1;
        ready = model_ready();
        if (m_known) begin
            chk("in_ready",   {31'd0, in_ready},   {31'd0, ready});
            chk("cw_valid",   {31'd0, cw_valid},   {31'd0, m_pv});
            chk("cw_count",   {16'd0, cw_count},   {16'd0, m_cwc});
            chk("drop_count", {16'd0, drop_count}, {16'd0, m_drc});
            if (m_pv) begin
                chk("codeword",       codeword,               m_pw);
                chk("codeword_width", {30'd0, codeword_width}, {30'd0, m_pwidth});
            end
        end
        if (!rst) begin
            m_bytes.delete();
            m_lw = 0; m_pv = 0; m_pw = 0; m_pwidth = 0; m_cwc = 0; m_drc = 0;
            m_known = 1;
        end else begin
            new_pv = m_pv && !rdy;
            if (m_pv && rdy) m_cwc++;
            if (v && ready) begin
                if (m_bytes.size() == 0) m_lw = w;
                m_bytes.push_back(b);
                n = nbytes(m_lw);
                if (m_bytes.size() == n) begin
                    word = 0;
                    for (int k = 0; k < n; k++) word = word + (32'(m_bytes[k]) << (8 * k));
                    m_pw = word; m_pwidth = m_lw; new_pv = 1;
                    m_bytes.delete();
                end else if (last) begin
                    m_drc++;
                    m_bytes.delete();
                end
            end
            m_pv = new_pv;
        end
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit rdy);
        cyc(1, 0, 8'h00, 0, 2'd0, rdy);
    endtask

    initial begin
        rst_n = 0; cfg_width = 0; in_byte = 0; in_valid = 0; in_last = 0; cw_ready = 0;

        cyc(0, 0, 8'h00, 0, 2'd0, 0);
        cyc(0, 0, 8'h00, 0, 2'd0, 0);
        after_edge();
        chk("rst cw_valid",   {31'd0, cw_valid}, 32'd0);
        chk("rst codeword",   codeword, 32'd0);
        chk("rst width",      {30'd0, codeword_width}, 32'd0);
        chk("rst cw_count",   {16'd0, cw_count}, 32'd0);
        chk("rst drop_count", {16'd0, drop_count}, 32'd0);
        chk("rst in_ready",   {31'd0, in_ready}, 32'd0);

        // 8-bit words back to back
        cyc(1, 1, 8'hA5, 0, 2'd0, 1);
        after_edge();
        chk("w8 first", codeword, 32'h0000_00A5);
        chk("w8 first valid", {31'd0, cw_valid}, 32'd1);
        cyc(1, 1, 8'h3C, 0, 2'd0, 1);
        after_edge();
        chk("w8 second", codeword, 32'h0000_003C);
        idle(1);
        after_edge();
        chk("w8 count", {16'd0, cw_count}, 32'd2);

        // 16-bit word
        cyc(1, 1, 8'h34, 0, 2'd1, 1);
        cyc(1, 1, 8'h12, 0, 2'd1, 1);
        after_edge();
        chk("w16 word", codeword, 32'h0000_1234);
        chk("w16 width", {30'd0, codeword_width}, 32'd1);
        idle(1);

        // 32-bit word with cfg_width changed mid-codeword
        cyc(1, 1, 8'h78, 0, 2'd2, 1);
        cyc(1, 1, 8'h56, 0, 2'd0, 1);
        cyc(1, 1, 8'h34, 0, 2'd0, 1);
        cyc(1, 1, 8'h12, 0, 2'd0, 1);
        after_edge();
        chk("w32 word", codeword, 32'h1234_5678);
        chk("w32 width", {30'd0, codeword_width}, 32'd2);
        idle(1);

        // width 11 aliases 32-bit
        cyc(1, 1, 8'hEF, 0, 2'd3, 1);
        cyc(1, 1, 8'hBE, 0, 2'd3, 1);
        cyc(1, 1, 8'hAD, 0, 2'd3, 1);
        cyc(1, 1, 8'hDE, 0, 2'd3, 1);
        after_edge();
        chk("w11 word", codeword, 32'hDEAD_BEEF);
        chk("w11 width", {30'd0, codeword_width}, 32'd3);
        idle(1);

        // backpressure on the final byte, then simultaneous drain and load
        cyc(1, 1, 8'h11, 0, 2'd2, 0);
        cyc(1, 1, 8'h22, 0, 2'd2, 0);
        cyc(1, 1, 8'h33, 0, 2'd2, 0);
        cyc(1, 1, 8'h44, 0, 2'd2, 0);
        cyc(1, 1, 8'h55, 0, 2'd2, 0);
        cyc(1, 1, 8'h66, 0, 2'd2, 0);
        cyc(1, 1, 8'h77, 0, 2'd2, 0);
        cyc(1, 1, 8'h88, 0, 2'd2, 0);
        chk("bp in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp held word", codeword, 32'h4433_2211);
        cyc(1, 1, 8'h88, 0, 2'd2, 1);
        after_edge();
        chk("bp new word", codeword, 32'h8877_6655);
        chk("bp valid", {31'd0, cw_valid}, 32'd1);
        chk("bp count", {16'd0, cw_count}, 32'd6);
        idle(1);

        // partial word dropped on in_last
        cyc(1, 1, 8'hEE, 1, 2'd1, 1);
        after_edge();
        chk("drop valid", {31'd0, cw_valid}, 32'd0);
        chk("drop count", {16'd0, drop_count}, 32'd1);
        cyc(1, 1, 8'h01, 0, 2'd1, 1);
        cyc(1, 1, 8'h02, 1, 2'd1, 1);
        after_edge();
        chk("after drop word", codeword, 32'h0000_0201);
        chk("after drop count", {16'd0, drop_count}, 32'd1);
        idle(1);

        // reset with a pending word and a partial word
        cyc(1, 1, 8'hA1, 0, 2'd2, 0);
        cyc(1, 1, 8'hA2, 0, 2'd2, 0);
        cyc(1, 1, 8'hA3, 0, 2'd2, 0);
        cyc(1, 1, 8'hA4, 0, 2'd2, 0);
        cyc(1, 1, 8'hB1, 0, 2'd2, 0);
        cyc(1, 1, 8'hB2, 0, 2'd2, 0);
        cyc(0, 0, 8'h00, 0, 2'd2, 0);
        after_edge();
        chk("mid rst valid", {31'd0, cw_valid}, 32'd0);
        chk("mid rst cw_count", {16'd0, cw_count}, 32'd0);
        chk("mid rst drop_count", {16'd0, drop_count}, 32'd0);
        idle(0);
        chk("mid rst in_ready", {31'd0, in_ready}, 32'd1);
        cyc(1, 1, 8'hC1, 0, 2'd2, 1);
        cyc(1, 1, 8'hC2, 0, 2'd2, 1);
        cyc(1, 1, 8'hC3, 0, 2'd2, 1);
        cyc(1, 1, 8'hC4, 0, 2'd2, 1);
        after_edge();
        chk("post rst word", codeword, 32'hC4C3_C2C1);
        chk("post rst valid", {31'd0, cw_valid}, 32'd1);

        // randomized traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 299) != 0,
                $urandom_range(0, 9) < 7,
                8'($urandom),
                $urandom_range(0, 7) == 0,
                2'($urandom_range(0, 3)),
                $urandom_range(0, 9) < 6);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
